// File: rtl/fact_scheduler_pkg.sv
// fact_sched_pkg: state encoding and factorial-unit register map shared by the scheduler
package fact_sched_pkg;
    typedef enum logic [2:0] {IDLE, DISP_N, DISP_GO, POLL, RD_RES, DELIVER} state_t;
    localparam int NUM_UNITS = 4;
    localparam logic [31:0] CTRL_OFF = 32'h0;
    localparam logic [31:0] STATUS_OFF = 32'h4;
    localparam logic [31:0] N_OFF = 32'h8;
    localparam logic [31:0] RESULT_OFF = 32'hC;
    localparam int DONE_BIT = 0;
    localparam int ERR_BIT = 1;
endpackage

// File: rtl/fact_scheduler_if.sv
// fact_sched_if: job, result and memory-bus signals of the factorial scheduler
interface fact_sched_if;
    import fact_sched_pkg::*;
    logic job_valid, job_ready;
    logic [3:0] job_n, job_tag;
    logic res_valid, res_ready, res_err, irq;
    logic [31:0] res_data;
    logic [3:0] res_tag;
    logic bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [NUM_UNITS-1:0] busy_mask;
    modport master (
        input job_valid, job_n, job_tag, res_ready, bus_rdata,
        output job_ready, res_valid, res_data, res_tag, res_err, irq, bus_we, bus_addr, bus_wdata, busy_mask
    );
    modport slave (
        output job_valid, job_n, job_tag, res_ready, bus_rdata,
        input job_ready, res_valid, res_data, res_tag, res_err, irq, bus_we, bus_addr, bus_wdata, busy_mask
    );
endinterface

// File: rtl/fact_scheduler_rr_pick.sv
// rr_pick: first requesting index at or after ptr, wrapping around four slots
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);
    always_comb begin
        found = |req;
        idx = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + 2'(i)]) idx = ptr + 2'(i);
    end
endmodule

// File: rtl/fact_scheduler.sv
// fact_scheduler: round-robin dispatch of factorial jobs onto four memory-mapped units
module fact_scheduler
    import fact_sched_pkg::*;
#(
    parameter logic [31:0] FACT_BASE = 32'h0000_0A00,
    parameter logic [31:0] FACT_STRIDE = 32'h0000_0100
) (
    input logic clk,
    input logic rst,
    fact_sched_if.master sif
);
    state_t st, nxt;
    logic [3:0] busy;
    logic [3:0] tags [4];
    logic [1:0] disp_ptr, poll_ptr, sel, d_idx, p_idx;
    logic prefer_poll, d_found, p_found, take_job, take_poll, err_q;
    logic [3:0] n_q, tag_q, rtag_q;
    logic [31:0] data_q, unit_base;

    rr_pick u_disp (.req(~busy), .ptr(disp_ptr), .found(d_found), .idx(d_idx));
    rr_pick u_poll (.req(busy), .ptr(poll_ptr), .found(p_found), .idx(p_idx));

    assign unit_base = FACT_BASE + 32'(sel) * FACT_STRIDE;
    // prefer_poll alternates dispatch and poll so neither starves under load
    assign take_job = st == IDLE && sif.job_valid && d_found && (!prefer_poll || !p_found);
    assign take_poll = st == IDLE && !take_job && p_found;

    always_comb begin
        nxt = st;
        sif.bus_we = 1'b0;
        sif.bus_addr = '0;
        sif.bus_wdata = '0;
        case (st)
            IDLE: nxt = take_job ? DISP_N : take_poll ? POLL : IDLE;
            DISP_N: begin
                sif.bus_we = 1'b1;
                sif.bus_addr = unit_base + N_OFF;
                sif.bus_wdata = {28'b0, n_q};
                nxt = DISP_GO;
            end
            DISP_GO: begin
                sif.bus_we = 1'b1;
                sif.bus_addr = unit_base + CTRL_OFF;
                sif.bus_wdata = 32'd1;
                nxt = IDLE;
            end
            POLL: begin
                sif.bus_addr = unit_base + STATUS_OFF;
                nxt = sif.bus_rdata[DONE_BIT] ? RD_RES : IDLE;
            end
            RD_RES: begin
                sif.bus_addr = unit_base + RESULT_OFF;
                nxt = DELIVER;
            end
            DELIVER: nxt = sif.res_ready ? IDLE : DELIVER;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            busy <= '0;
            tags <= '{default: '0};
            disp_ptr <= '0;
            poll_ptr <= '0;
            prefer_poll <= 1'b0;
            sel <= '0;
            n_q <= '0;
            tag_q <= '0;
            data_q <= '0;
            rtag_q <= '0;
            err_q <= 1'b0;
        end else begin
            st <= nxt;
            if (take_job) begin
                sel <= d_idx;
                disp_ptr <= d_idx + 2'd1;
                n_q <= sif.job_n;
                tag_q <= sif.job_tag;
                prefer_poll <= 1'b1;
            end else if (take_poll) begin
                sel <= p_idx;
                poll_ptr <= p_idx + 2'd1;
                prefer_poll <= 1'b0;
            end
            if (st == DISP_GO) begin
                busy[sel] <= 1'b1;
                tags[sel] <= tag_q;
            end
            if (st == POLL && sif.bus_rdata[DONE_BIT]) err_q <= sif.bus_rdata[ERR_BIT];
            if (st == RD_RES) begin
                data_q <= sif.bus_rdata;
                rtag_q <= tags[sel];
            end
            if (st == DELIVER && sif.res_ready) busy[sel] <= 1'b0;
        end
    end

    assign sif.job_ready = take_job;
    assign sif.res_valid = st == DELIVER;
    assign sif.irq = st == DELIVER;
    assign sif.res_data = data_q;
    assign sif.res_tag = rtag_q;
    assign sif.res_err = err_q;
    assign sif.busy_mask = busy;
endmodule

// File: tb/tb_fact_scheduler.sv
// tb_fact_scheduler: directed checks of fact_scheduler against four behavioural factorial units
module tb_fact_scheduler;
    localparam logic [31:0] BASE = 32'h0000_0A00;
    localparam logic [31:0] STRIDE = 32'h0000_0100;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    fact_sched_if f();
    fact_scheduler #(.FACT_BASE(BASE), .FACT_STRIDE(STRIDE)) dut (.clk(clk), .rst(rst), .sif(f.master));
    always #5 clk = ~clk;

    logic [31:0] u_n [4] = '{default: 32'd0};
    logic u_done [4] = '{default: 1'b0};
    int u_cnt [4] = '{default: 0};
    int lat [4] = '{default: 10};
    logic [63:0] wr_q [$];
    logic [31:0] n_addr [4] = '{32'h0000_0A08, 32'h0000_0B08, 32'h0000_0C08, 32'h0000_0D08};
    logic [31:0] go_addr [4] = '{32'h0000_0A00, 32'h0000_0B00, 32'h0000_0C00, 32'h0000_0D00};
    logic [31:0] fact_res [4] = '{32'd6, 32'd24, 32'd120, 32'd720};

    function automatic logic [31:0] fact(input logic [31:0] n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    // Unit model: Done rises lat[k] cycles after a CTRL start; Err when N > 12
    always_comb begin
        f.bus_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            if (f.bus_addr == BASE + STRIDE * k + 32'h4) f.bus_rdata = {30'b0, u_n[k] > 32'd12, u_done[k]};
            if (f.bus_addr == BASE + STRIDE * k + 32'hC) f.bus_rdata = u_n[k] > 32'd12 ? 32'h0 : fact(u_n[k]);
        end
    end

    always @(posedge clk) begin
        if (f.bus_we) wr_q.push_back({f.bus_addr, f.bus_wdata});
        for (int k = 0; k < 4; k++) begin
            if (f.bus_we && f.bus_addr == BASE + STRIDE * k + 32'h8) u_n[k] <= f.bus_wdata;
            if (f.bus_we && f.bus_addr == BASE + STRIDE * k && f.bus_wdata[0]) begin
                u_done[k] <= 1'b0;
                u_cnt[k] <= lat[k];
            end else if (u_cnt[k] > 1) u_cnt[k] <= u_cnt[k] - 1;
            else if (u_cnt[k] == 1) begin
                u_cnt[k] <= 0;
                u_done[k] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        f.job_valid = 1'b0;
        f.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic send(input logic [3:0] n, input logic [3:0] t);
        int w = 0;
        @(negedge clk);
        f.job_valid = 1'b1;
        f.job_n = n;
        f.job_tag = t;
        #1;
        while (!f.job_ready && w < 2000) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("send_accept", 64'(w < 2000), 64'd1);
        @(negedge clk);
        f.job_valid = 1'b0;
    endtask

    task automatic wait_res();
        int w = 0;
        #1;
        while (!f.res_valid && w < 2000) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("res_wait", 64'(w < 2000), 64'd1);
    endtask

    task automatic handshake();
        f.res_ready = 1'b1;
        @(negedge clk);
        f.res_ready = 1'b0;
        #1;
    endtask

    initial begin
        int b, cnt, bad;
        logic [31:0] d0;
        f.job_valid = 1'b0;
        f.job_n = '0;
        f.job_tag = '0;
        f.res_ready = 1'b0;
        reset_dut();
        check("rst_res_valid", f.res_valid, 0);
        check("rst_irq", f.irq, 0);
        check("rst_job_ready", f.job_ready, 0);
        check("rst_bus_we", f.bus_we, 0);
        check("rst_bus_addr", f.bus_addr, 0);
        check("rst_bus_wdata", f.bus_wdata, 0);
        check("rst_busy_mask", f.busy_mask, 0);
        check("rst_res_data", f.res_data, 0);
        check("rst_res_tag", f.res_tag, 0);
        check("rst_res_err", f.res_err, 0);

        // single job
        b = wr_q.size();
        send(4'd5, 4'd3);
        wait_res();
        check("t1_wr_n", wr_q[b], {32'h0000_0A08, 32'd5});
        check("t1_wr_go", wr_q[b+1], {32'h0000_0A00, 32'd1});
        check("t1_data", f.res_data, 32'd120);
        check("t1_tag", f.res_tag, 4'd3);
        check("t1_err", f.res_err, 0);
        check("t1_irq", f.irq, 1);
        check("t1_mask", f.busy_mask, 4'b0001);
        handshake();
        check("t1_mask_clr", f.busy_mask, 4'b0000);

        // five jobs on slow units
        reset_dut();
        lat = '{300, 300, 300, 300};
        b = wr_q.size();
        for (int k = 0; k < 4; k++) send(4'(k + 3), 4'(k + 1));
        @(negedge clk);
        f.job_valid = 1'b1;
        f.job_n = 4'd7;
        f.job_tag = 4'd5;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (f.job_ready) cnt++;
            @(negedge clk);
        end
        check("t2_blocked", 64'(cnt), 0);
        check("t2_mask_full", f.busy_mask, 4'hF);
        for (int k = 0; k < 4; k++) begin
            check("t2_wr_n", wr_q[b+2*k], {n_addr[k], 32'(k + 3)});
            check("t2_wr_go", wr_q[b+2*k+1], {go_addr[k], 32'd1});
        end
        wait_res();
        check("t2_first_tag", f.res_tag, 4'd1);
        check("t2_first_data", f.res_data, 32'd6);
        handshake();
        check("t2_ready_freed", f.job_ready, 1);
        @(negedge clk);
        f.job_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_job5_n", wr_q[b+8], {32'h0000_0A08, 32'd7});
        check("t2_job5_go", wr_q[b+9], {32'h0000_0A00, 32'd1});

        // out-of-order completion with a held result
        reset_dut();
        lat = '{60, 80, 5, 300};
        send(4'd2, 4'd7);
        send(4'd3, 4'd8);
        send(4'd4, 4'd9);
        wait_res();
        check("t3_tag_u2", f.res_tag, 4'd9);
        check("t3_data_u2", f.res_data, 32'd24);
        check("t3_mask_pre", f.busy_mask, 4'b0111);
        d0 = f.res_data;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (!f.res_valid || !f.irq || f.res_data != d0 || f.bus_we || f.bus_addr != 0) bad++;
        end
        check("t3_hold", 64'(bad), 0);
        handshake();
        check("t3_mask_u2_clr", f.busy_mask, 4'b0011);
        wait_res();
        check("t3_tag_u0", f.res_tag, 4'd7);
        check("t3_data_u0", f.res_data, 32'd2);
        handshake();
        check("t3_mask_u0_clr", f.busy_mask, 4'b0010);
        wait_res();
        check("t3_tag_u1", f.res_tag, 4'd8);
        check("t3_data_u1", f.res_data, 32'd6);
        handshake();
        check("t3_mask_empty", f.busy_mask, 4'b0000);

        // out-of-range operand
        reset_dut();
        lat = '{10, 10, 10, 10};
        send(4'd13, 4'hA);
        wait_res();
        check("t5_err", f.res_err, 1);
        check("t5_tag", f.res_tag, 4'hA);
        handshake();

        // reset while in DISP_GO
        reset_dut();
        @(negedge clk);
        f.job_valid = 1'b1;
        f.job_n = 4'd6;
        f.job_tag = 4'd2;
        #1;
        check("t6_accept", f.job_ready, 1);
        @(negedge clk);
        f.job_valid = 1'b0;
        #1;
        check("t6_disp_n_addr", f.bus_addr, 32'h0000_0A08);
        @(negedge clk);
        #1;
        check("t6_disp_go_addr", f.bus_addr, 32'h0000_0A00);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t6_rst_bus_we", f.bus_we, 0);
        check("t6_rst_bus_addr", f.bus_addr, 0);
        check("t6_rst_job_ready", f.job_ready, 0);
        check("t6_rst_res_valid", f.res_valid, 0);
        check("t6_rst_mask", f.busy_mask, 0);
        rst = 1'b0;
        b = wr_q.size();
        send(4'd6, 4'd2);
        wait_res();
        check("t6_redisp_n", wr_q[b], {32'h0000_0A08, 32'd6});
        check("t6_data", f.res_data, fact_res[3]);
        check("t6_tag", f.res_tag, 4'd2);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fact_scheduler.md
# fact_scheduler

Job scheduler that shares the four memory-mapped factorial units among a stream of factorial requests. It accepts jobs on a valid/ready port and dispatches each to a free unit in round-robin order by issuing bus writes through the SoC memory map. It polls busy units for completion, reads back results, and returns them with the job tag on a result port. `irq` toward the interrupt controller is asserted while a result is pending.

## Interface
Parameters:
- `FACT_BASE`, 32'h0000_0A00: bus address of factorial unit 0.
- `FACT_STRIDE`, 32'h0000_0100: address distance between consecutive units; unit k is at `FACT_BASE + k*FACT_STRIDE`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  job request present.
- `job_ready`  out  1  job accepted this cycle when `job_valid & job_ready`.
- `job_n`  in  4  factorial operand.
- `job_tag`  in  4  opaque job ID, returned with the result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.
- `res_data`  out  32  factorial result.
- `res_tag`  out  4  tag of the completed job.
- `res_err`  out  1  unit reported error (operand out of range).
- `irq`  out  1  equals `res_valid`.
- `bus_we`  out  1  bus write enable, toward the memory map write_enable.
- `bus_addr`  out  32  bus address.
- `bus_wdata`  out  32  bus write data.
- `bus_rdata`  in  32  bus read data; combinational, valid in the same cycle as `bus_addr`.
- `busy_mask`  out  4  bit k set while unit k holds a job.

## Operation
Factorial unit register offsets:
- 0x0 CTRL: writing bit0=1 starts the unit and clears Done.
- 0x4 STATUS: bit0 Done, bit1 Err.
- 0x8 N: operand.
- 0xC RESULT.

Per-unit state:
- `busy[k]`
- `tag[k]`, 4 bits

Pointers:
- `disp_ptr` and `poll_ptr`, 2 bits each.
- Both select via round-robin: the first qualifying unit at or after the pointer, with wrap.
- After use, the pointer moves to the selected unit + 1.

State machine: IDLE, DISP_N, DISP_GO, POLL, RD_RES, DELIVER. `prefer_poll` is a toggle bit.
- IDLE, dispatch: taken if `job_valid`, some unit is free, and either `!prefer_poll` or no unit is busy.
  - `job_ready`=1; latch n and tag; select free unit d.
  - Next state DISP_N; set `prefer_poll`.
- IDLE, poll: otherwise, if any unit is busy.
  - Select busy unit p; next state POLL; clear `prefer_poll`.
- IDLE, neither: stay in IDLE.
- DISP_N: write N of unit d with `{28'b0, n}`.
- DISP_GO: write CTRL of unit d with 1. Set `busy[d]`, store `tag[d]`, return to IDLE.
- POLL: read STATUS of unit p.
  - Done=1: capture Err, go to RD_RES.
  - Done=0: go to IDLE.
- RD_RES: read RESULT of unit p into `res_data`; `res_tag = tag[p]`. Go to DELIVER.
- DELIVER: `res_valid`=1. On handshake, clear `busy[p]` and go to IDLE. Hold indefinitely otherwise; no dispatch or poll occurs while holding.
- `job_ready` is 0 in every state except the dispatch cycle of IDLE.
- `bus_we` is 1 only in DISP_N and DISP_GO.
- `bus_addr` and `bus_wdata` are 0 when the bus is unused.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `tag` all 0
  - `disp_ptr`=0, `poll_ptr`=0, `prefer_poll`=0
  - outputs: `job_ready`, `res_valid`, `irq`, `bus_we`, `res_err` all 0; `res_data`, `res_tag`, `bus_addr`, `bus_wdata` all 0; `busy_mask`=0
- Dispatch: accept at cycle T. N write at T+1, CTRL write at T+2. `busy_mask` bit visible at T+3.
- Completion detection: POLL at cycle P, RESULT read at P+1. `res_valid` rises at P+2, at the earliest.
- Result returned to IDLE: handshake at cycle H, back in IDLE at H+1. The freed unit may be dispatched at H+1.
- All four units busy: `job_ready` stays 0; only polling proceeds.
- No jobs pending: back-to-back polling cycles through busy units.
- Simultaneous job arrival and busy units: dispatch and poll alternate via `prefer_poll`. Neither starves.
- Reset mid-operation:
  - All in-flight jobs and pending results are dropped; `busy` clears.
  - Units already started keep running, and are re-armed by the next CTRL write.
- `job_n` > 12: passed through unchanged. The unit flags Err; the scheduler still returns a result, with `res_err`=1.

## Structure
- Shared package `fact_sched_pkg` contains:
  - state encoding enum
  - register offsets `CTRL_OFF`, `STATUS_OFF`, `N_OFF`, `RESULT_OFF`
  - STATUS bit positions
  - `NUM_UNITS`=4
- Sub-module `rr_pick`:
  - Inputs: 4-bit request mask and 2-bit pointer.
  - Outputs: `found` and a 2-bit index.
  - Instantiated twice: once on `~busy` for dispatch, once on `busy` for poll.

## Test plan
- Single job: n=5, tag=3, unit model Done after 10 cycles.
  - Bus shows 0xA08←5 then 0xA00←1.
  - Result returned: `res_data`=120, `res_tag`=3, `res_err`=0.
- Five jobs back-to-back with slow units:
  - Dispatched to units 0, 1, 2, 3 in order (0xA08, 0xB08, 0xC08, 0xD08).
  - `job_ready` held 0 for job 5 until a result handshake frees a unit.
- Out-of-order completion: unit 2 finishes before unit 0.
  - Result for unit 2 is returned first with its own tag; `busy_mask` bit 2 clears first.
- `res_ready` held 0 for 20 cycles:
  - `res_valid`/`irq` stay 1 with stable data; no bus activity.
  - Single handshake, then resume.
- n=13: unit returns Err → `res_err`=1 and `res_tag` is preserved.
- `rst` asserted during DISP_GO:
  - Next cycle: all outputs at reset values and `busy_mask`=0.
  - A new job then dispatches to unit 0.
